// File: rtl/eq_adapt_pkg.sv
// ----------------------------------------------------------------------------
// eq_adapt_pkg
//   Shared types for the equalizer adaptation sequencer.
//   - adapt_state_t : sequencer state (IDLE, STARTUP, CMA, LMS, HOLD)
//   - PH_*          : phase codes driven on o_phase toward the adaptation engine
//   - phase_of()    : maps a state onto its phase code
// ----------------------------------------------------------------------------
package eq_adapt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_CMA     = 3'd2,
        ST_LMS     = 3'd3,
        ST_HOLD    = 3'd4
    } adapt_state_t;

    localparam logic [2:0] PH_STARTUP = 3'b000;  // also used while idle
    localparam logic [2:0] PH_CMA     = 3'b001;
    localparam logic [2:0] PH_LMS     = 3'b010;
    localparam logic [2:0] PH_HOLD    = 3'b011;

    function automatic logic [2:0] phase_of(input adapt_state_t s);
        logic [2:0] ph;
        case (s)
            ST_CMA:  ph = PH_CMA;
            ST_LMS:  ph = PH_LMS;
            ST_HOLD: ph = PH_HOLD;
            default: ph = PH_STARTUP;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/err_power_avg.sv
// ----------------------------------------------------------------------------
// err_power_avg
//   Squares the signed slicer error and runs it through a first-order leaky
//   integrator:  p <= p + ((e^2 - p) >>> ALPHA_SH).
//   The difference is formed one bit wider than the power so it can go
//   negative; the arithmetic shift floors toward minus infinity, which keeps
//   the result between the old power and e^2, so it never underflows.
//
// Ports
//   clk        clock
//   rst_n      synchronous reset, active low (power -> 0)
//   clear      synchronous clear of the averaged power
//   sample_en  fold the current err into the average this cycle
//   err        signed slicer error, NB_ERR bits
//   pow        averaged error power, 2*NB_ERR bits unsigned (registered)
// ----------------------------------------------------------------------------
module err_power_avg #(
    parameter int NB_ERR   = 18,
    parameter int ALPHA_SH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     sample_en,
    input  logic signed [NB_ERR-1:0] err,
    output logic [2*NB_ERR-1:0]      pow
);

    localparam int NB_POW = 2 * NB_ERR;

    logic signed [NB_POW-1:0] err_ext;
    logic signed [NB_POW-1:0] err_sq;
    logic        [NB_POW-1:0] e2;
    logic signed [NB_POW:0]   diff;
    logic signed [NB_POW:0]   step;
    logic        [NB_POW-1:0] pow_next;

    // NOTE: every signal written here gets a value on every path through the
    // block; a missing assignment on any branch would infer a latch.
    always_comb begin
        err_ext  = $signed({{NB_ERR{err[NB_ERR-1]}}, err});
        // The square of the most negative input is 2^(2*NB_ERR-2), which
        // still fits the signed product, so reinterpreting it as unsigned
        // is exact.
        err_sq   = err_ext * err_ext;
        e2       = NB_POW'(err_sq);
        diff     = $signed({1'b0, e2}) - $signed({1'b0, pow});
        step     = diff >>> ALPHA_SH;
        pow_next = NB_POW'($signed({1'b0, pow}) + step);
    end

    // NOTE: the reset is synchronous -- it is sampled only at the clock edge,
    // so rst_n appears inside the block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pow <= '0;
        end else if (clear) begin
            pow <= '0;
        end else if (sample_en) begin
            pow <= pow_next;
        end
    end

endmodule

// File: rtl/adapt_phase_sequencer.sv
// ----------------------------------------------------------------------------
// adapt_phase_sequencer
//   Sequences the equalizer's adaptation engine: a startup wait, blind CMA,
//   then decision-directed LMS. The CMA->LMS switch is taken once the
//   averaged slicer-error power drops below i_conv_thr (after a minimum
//   dwell), or forcibly when the dwell reaches i_cma_max. A decimated
//   update strobe gates the engine's coefficient write.
//
//   Build option:
//     ADAPT_SEQ_DIVERGE_FALLBACK_EN  when defined, LMS falls back to CMA on a
//                                    valid sample where o_err_pow > i_div_thr
//                                    and o_diverged is set. Otherwise LMS is
//                                    terminal until restart/disable and
//                                    o_diverged stays 0.
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   enable        run adaptation; low sends the sequencer to IDLE
//   i_restart     pulse: back to STARTUP, clears counters, power and flags
//   i_freeze      level: park in HOLD, return to the frozen-from state
//   i_err_valid   qualifies i_err
//   i_err         signed slicer error
//   i_upd_div     update strobe every i_upd_div+1 valid samples
//   i_cma_min     minimum CMA dwell (valid samples) before a power switch
//   i_cma_max     CMA dwell at which LMS is forced (sets o_timeout)
//   i_conv_thr    power threshold for CMA->LMS
//   i_div_thr     divergence threshold (only with the build option)
//   o_phase       000 startup/idle, 001 CMA, 010 LMS, 011 hold
//   o_update_en   one-cycle coefficient-commit strobe
//   o_iter_count  strobes since last (re)start, saturating
//   o_err_pow     averaged error power
//   o_timeout     sticky: CMA left through i_cma_max
//   o_diverged    sticky: LMS fell back to CMA
// ----------------------------------------------------------------------------
module adapt_phase_sequencer
    import eq_adapt_pkg::*;
#(
    parameter int NB_ERR        = 18,
    parameter int NB_CNT        = 32,
    parameter int NB_DIV        = 4,
    parameter int ALPHA_SH      = 6,
    parameter int STARTUP_DELAY = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     i_restart,
    input  logic                     i_freeze,
    input  logic                     i_err_valid,
    input  logic signed [NB_ERR-1:0] i_err,
    input  logic [NB_DIV-1:0]        i_upd_div,
    input  logic [NB_CNT-1:0]        i_cma_min,
    input  logic [NB_CNT-1:0]        i_cma_max,
    input  logic [2*NB_ERR-1:0]      i_conv_thr,
    input  logic [2*NB_ERR-1:0]      i_div_thr,
    output logic [2:0]               o_phase,
    output logic                     o_update_en,
    output logic [NB_CNT-1:0]        o_iter_count,
    output logic [2*NB_ERR-1:0]      o_err_pow,
    output logic                     o_timeout,
    output logic                     o_diverged
);

    adapt_state_t      state;
    adapt_state_t      frozen_from;
    logic [NB_CNT-1:0] dwell;
    logic [NB_DIV-1:0] dec;

    logic [NB_CNT-1:0] dwell_inc;
    logic [NB_CNT-1:0] iter_inc;
    logic [NB_DIV-1:0] dec_inc;
    logic              dec_hit;
    logic              startup_done;
    logic              cma_conv;
    logic              cma_at_max;
    logic              lms_diverge;
    logic              pow_clear;
    logic              pow_sample;

    // Dwell values below already include the sample being processed, so a
    // minimum of N switches on the N-th valid sample of the phase.
    always_comb begin
        dwell_inc    = (dwell == '1) ? dwell : dwell + NB_CNT'(1);
        iter_inc     = (o_iter_count == '1) ? o_iter_count : o_iter_count + NB_CNT'(1);
        dec_inc      = dec + NB_DIV'(1);
        dec_hit      = (dec == i_upd_div);
        startup_done = (dwell_inc == NB_CNT'(STARTUP_DELAY));
        // Decisions look at the power before this sample is folded in.
        cma_conv     = (dwell_inc >= i_cma_min) && (o_err_pow < i_conv_thr);
        cma_at_max   = (dwell_inc == i_cma_max);
    end

`ifdef ADAPT_SEQ_DIVERGE_FALLBACK_EN
    assign lms_diverge = (o_err_pow > i_div_thr);
`else
    logic unused_div_thr;
    assign lms_diverge    = 1'b0;
    assign unused_div_thr = ^i_div_thr;
`endif

    // Power tracks in every non-IDLE state (HOLD included); it is held while
    // disabled and wiped by a restart.
    assign pow_clear  = enable && i_restart;
    assign pow_sample = enable && !i_restart && i_err_valid && (state != ST_IDLE);

    err_power_avg #(
        .NB_ERR   (NB_ERR),
        .ALPHA_SH (ALPHA_SH)
    ) u_err_power_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pow_clear),
        .sample_en (pow_sample),
        .err       (i_err),
        .pow       (o_err_pow)
    );

    // o_phase is computed from the next state so it moves on the same edge
    // as the state register. The update strobe is only raised on samples
    // that leave the phase unchanged.
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            frozen_from  <= ST_IDLE;
            dwell        <= '0;
            dec          <= '0;
            o_phase      <= PH_STARTUP;
            o_update_en  <= 1'b0;
            o_iter_count <= '0;
            o_timeout    <= 1'b0;
            o_diverged   <= 1'b0;
        end else begin
            o_update_en <= 1'b0;
            if (!enable) begin
                // Sticky flags survive a disable; counters do not.
                state        <= ST_IDLE;
                o_phase      <= PH_STARTUP;
                dwell        <= '0;
                dec          <= '0;
                o_iter_count <= '0;
            end else if (i_restart) begin
                state        <= ST_STARTUP;
                o_phase      <= PH_STARTUP;
                dwell        <= '0;
                dec          <= '0;
                o_iter_count <= '0;
                o_timeout    <= 1'b0;
                o_diverged   <= 1'b0;
            end else if (i_freeze && (state != ST_IDLE)) begin
                // Dwell and decimator simply stop; they are not reset.
                if (state != ST_HOLD) begin
                    frozen_from <= state;
                end
                state   <= ST_HOLD;
                o_phase <= PH_HOLD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_STARTUP;
                        o_phase <= PH_STARTUP;
                        dwell   <= '0;
                    end
                    ST_HOLD: begin
                        // Resuming is not a phase entry: counters carry on.
                        state   <= frozen_from;
                        o_phase <= phase_of(frozen_from);
                    end
                    ST_STARTUP: begin
                        if (i_err_valid) begin
                            if (startup_done) begin
                                state   <= ST_CMA;
                                o_phase <= PH_CMA;
                                dwell   <= '0;
                                dec     <= '0;
                            end else begin
                                dwell <= dwell_inc;
                            end
                        end
                    end
                    ST_CMA: begin
                        if (i_err_valid) begin
                            if (cma_conv || cma_at_max) begin
                                state   <= ST_LMS;
                                o_phase <= PH_LMS;
                                dwell   <= '0;
                                dec     <= '0;
                                // Only flagged when the dwell limit, not the
                                // power, caused the switch.
                                if (!cma_conv) begin
                                    o_timeout <= 1'b1;
                                end
                            end else begin
                                dwell <= dwell_inc;
                                if (dec_hit) begin
                                    o_update_en  <= 1'b1;
                                    o_iter_count <= iter_inc;
                                    dec          <= '0;
                                end else begin
                                    dec <= dec_inc;
                                end
                            end
                        end
                    end
                    ST_LMS: begin
                        if (i_err_valid) begin
                            if (lms_diverge) begin
                                state      <= ST_CMA;
                                o_phase    <= PH_CMA;
                                dwell      <= '0;
                                dec        <= '0;
                                o_diverged <= 1'b1;
                            end else begin
                                dwell <= dwell_inc;
                                if (dec_hit) begin
                                    o_update_en  <= 1'b1;
                                    o_iter_count <= iter_inc;
                                    dec          <= '0;
                                end else begin
                                    dec <= dec_inc;
                                end
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        o_phase <= PH_STARTUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adapt_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adapt_phase_sequencer
//   Self-checking bench for adapt_phase_sequencer. A behavioural model of the
//   sequencing rules runs beside the DUT and every output is compared each
//   cycle; a table of scenarios adds hand-derived end-point expectations, and
//   a few directed sequences cover freeze, restart, disable, reset and the
//   optional divergence fallback (ADAPT_SEQ_DIVERGE_FALLBACK_EN).
// ----------------------------------------------------------------------------
module tb_adapt_phase_sequencer;

    localparam int NB_ERR        = 18;
    localparam int NB_CNT        = 32;
    localparam int NB_DIV        = 4;
    localparam int ALPHA_SH      = 6;
    localparam int STARTUP_DELAY = 63;
    localparam int NB_POW        = 2 * NB_ERR;

`ifdef ADAPT_SEQ_DIVERGE_FALLBACK_EN
    localparam bit FALLBACK = 1'b1;
`else
    localparam bit FALLBACK = 1'b0;
`endif

    localparam longint CNT_MAX = (longint'(1) << NB_CNT) - 1;

    // Model modes (names only; the DUT encoding is not used here).
    localparam int M_IDLE    = 0;
    localparam int M_STARTUP = 1;
    localparam int M_CMA     = 2;
    localparam int M_LMS     = 3;
    localparam int M_HOLD    = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic                     i_restart;
    logic                     i_freeze;
    logic                     i_err_valid;
    logic signed [NB_ERR-1:0] i_err;
    logic [NB_DIV-1:0]        i_upd_div;
    logic [NB_CNT-1:0]        i_cma_min;
    logic [NB_CNT-1:0]        i_cma_max;
    logic [NB_POW-1:0]        i_conv_thr;
    logic [NB_POW-1:0]        i_div_thr;
    logic [2:0]               o_phase;
    logic                     o_update_en;
    logic [NB_CNT-1:0]        o_iter_count;
    logic [NB_POW-1:0]        o_err_pow;
    logic                     o_timeout;
    logic                     o_diverged;

    adapt_phase_sequencer #(
        .NB_ERR        (NB_ERR),
        .NB_CNT        (NB_CNT),
        .NB_DIV        (NB_DIV),
        .ALPHA_SH      (ALPHA_SH),
        .STARTUP_DELAY (STARTUP_DELAY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .i_restart    (i_restart),
        .i_freeze     (i_freeze),
        .i_err_valid  (i_err_valid),
        .i_err        (i_err),
        .i_upd_div    (i_upd_div),
        .i_cma_min    (i_cma_min),
        .i_cma_max    (i_cma_max),
        .i_conv_thr   (i_conv_thr),
        .i_div_thr    (i_div_thr),
        .o_phase      (o_phase),
        .o_update_en  (o_update_en),
        .o_iter_count (o_iter_count),
        .o_err_pow    (o_err_pow),
        .o_timeout    (o_timeout),
        .o_diverged   (o_diverged)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int     m_mode    = M_IDLE;
    int     m_saved   = M_IDLE;
    longint m_dwell   = 0;
    int     m_dec     = 0;
    longint m_iter    = 0;
    longint m_pow     = 0;
    bit     m_upd     = 1'b0;
    bit     m_timeout = 1'b0;
    bit     m_diverged = 1'b0;

    function automatic longint floor_div(input longint num, input longint den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    function automatic logic [2:0] exp_phase(input int mode);
        case (mode)
            M_CMA:   return 3'b001;
            M_LMS:   return 3'b010;
            M_HOLD:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    task automatic m_enter(input int mode);
        m_mode  = mode;
        m_dwell = 0;
        m_dec   = 0;
    endtask

    // One adaptation sample counted toward the update decimation.
    task automatic m_count_sample();
        if (m_dec == int'(i_upd_div)) begin
            m_upd  = 1'b1;
            m_dec  = 0;
            m_iter = (m_iter == CNT_MAX) ? CNT_MAX : m_iter + 1;
        end else begin
            m_dec = (m_dec + 1) % (1 << NB_DIV);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        longint old_pow;
        longint ev;
        longint nd;
        m_upd = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_saved = M_IDLE; m_dwell = 0; m_dec = 0;
            m_iter = 0; m_pow = 0; m_timeout = 1'b0; m_diverged = 1'b0;
        end else if (!enable) begin
            m_mode = M_IDLE; m_dwell = 0; m_dec = 0; m_iter = 0;
        end else if (i_restart) begin
            m_mode = M_STARTUP; m_dwell = 0; m_dec = 0; m_iter = 0;
            m_pow = 0; m_timeout = 1'b0; m_diverged = 1'b0;
        end else begin
            old_pow = m_pow;
            if (m_mode != M_IDLE && i_err_valid) begin
                ev    = longint'(i_err);
                m_pow = old_pow + floor_div(ev * ev - old_pow, longint'(1) << ALPHA_SH);
            end
            nd = (m_dwell == CNT_MAX) ? CNT_MAX : m_dwell + 1;
            if (i_freeze && m_mode != M_IDLE) begin
                if (m_mode != M_HOLD) m_saved = m_mode;
                m_mode = M_HOLD;
            end else if (m_mode == M_IDLE) begin
                m_enter(M_STARTUP);
            end else if (m_mode == M_HOLD) begin
                m_mode = m_saved;
            end else if (i_err_valid) begin
                if (m_mode == M_STARTUP) begin
                    if (nd == STARTUP_DELAY) m_enter(M_CMA);
                    else m_dwell = nd;
                end else if (m_mode == M_CMA) begin
                    if (nd >= longint'(i_cma_min) && old_pow < longint'(i_conv_thr)) begin
                        m_enter(M_LMS);
                    end else if (nd == longint'(i_cma_max)) begin
                        m_enter(M_LMS);
                        m_timeout = 1'b1;
                    end else begin
                        m_dwell = nd;
                        m_count_sample();
                    end
                end else begin
                    if (FALLBACK && old_pow > longint'(i_div_thr)) begin
                        m_enter(M_CMA);
                        m_diverged = 1'b1;
                    end else begin
                        m_dwell = nd;
                        m_count_sample();
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("phase",    64'(o_phase),      64'(exp_phase(m_mode)));
        check("update",   64'(o_update_en),  64'(m_upd));
        check("iter",     64'(o_iter_count), 64'(m_iter));
        check("err_pow",  64'(o_err_pow),    64'(m_pow));
        check("timeout",  64'(o_timeout),    64'(m_timeout));
        check("diverged", 64'(o_diverged),   64'(m_diverged));
    endtask

    task automatic set_cfg(input int div, input longint cmin, input longint cmax,
                           input longint thr, input longint dthr);
        i_upd_div  = NB_DIV'(div);
        i_cma_min  = NB_CNT'(cmin);
        i_cma_max  = NB_CNT'(cmax);
        i_conv_thr = NB_POW'(thr);
        i_div_thr  = NB_POW'(dthr);
    endtask

    task automatic do_restart();
        i_restart   = 1'b1;
        i_err_valid = 1'b0;
        step();
        i_restart   = 1'b0;
    endtask

    // n valid samples with alternating-sign error of magnitude mag
    task automatic run_samples(input int n, input int mag);
        for (int k = 0; k < n; k++) begin
            i_err_valid = 1'b1;
            i_err       = NB_ERR'((k % 2 == 0) ? mag : -mag);
            step();
        end
    endtask

    typedef struct {
        int     div;
        longint cmin;
        longint cmax;
        longint thr;
        int     mag;
        int     n;
        int     exp_ph;
        int     exp_iter;
        bit     exp_to;
        bit     exp_upd;
    } vec_t;

    vec_t tbl[9];

    int     frz_left;
    int     err_mag;
    longint pow_before;

    task automatic randomize_cfg();
        int sel;
        sel = int'($urandom_range(0, 3));
        set_cfg(int'($urandom_range(0, 3)), longint'($urandom_range(0, 40)),
                longint'($urandom_range(0, 80)),
                (sel == 0) ? 0 : (sel == 1) ? 64 : (sel == 2) ? 5000 : longint'($urandom_range(0, 200000)),
                longint'($urandom_range(0, 20000)));
        case ($urandom_range(0, 4))
            0:       err_mag = 3;
            1:       err_mag = 30;
            2:       err_mag = 300;
            3:       err_mag = 3000;
            default: err_mag = 131072;
        endcase
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; i_restart = 1'b0; i_freeze = 1'b0;
        i_err_valid = 1'b0; i_err = '0;
        set_cfg(0, 0, 0, 0, 0);
        frz_left = 0;
        err_mag  = 4;

        // Reset state
        step();
        step();
        check("rst.phase", 64'(o_phase), 64'(3'b000));
        check("rst.update", 64'(o_update_en), 64'(0));
        check("rst.iter", 64'(o_iter_count), 64'(0));
        check("rst.pow", 64'(o_err_pow), 64'(0));
        rst_n  = 1'b1;
        enable = 1'b1;

        //            div cmin  cmax  thr   mag   n    ph it  to upd
        tbl[0] = '{0, 1000, 5000, 1000, 4,    62,  0, 0,  0, 0};  // still in startup
        tbl[1] = '{0, 1000, 5000, 1000, 4,    63,  1, 0,  0, 0};  // 63rd sample -> CMA
        tbl[2] = '{3, 100,  1000, 1000, 4,    162, 1, 24, 0, 0};  // CMA sample 99
        tbl[3] = '{3, 100,  1000, 1000, 4,    163, 2, 24, 0, 0};  // switch on sample 100
        tbl[4] = '{3, 1000, 5000, 0,    4,    103, 1, 10, 0, 1};  // decimation by 4
        tbl[5] = '{0, 1,    1000, 1000, 4,    64,  2, 0,  0, 0};  // immediate switch
        tbl[6] = '{1, 10,   1000, 1000, -3,   73,  2, 4,  0, 0};
        tbl[7] = '{0, 100,  200,  1000, 2000, 262, 1, 199, 0, 1}; // one short of max
        tbl[8] = '{0, 100,  200,  1000, 2000, 263, 2, 199, 1, 0}; // forced switch

        for (int r = 0; r < 9; r++) begin
            set_cfg(tbl[r].div, tbl[r].cmin, tbl[r].cmax, tbl[r].thr, 0);
            do_restart();
            run_samples(tbl[r].n, tbl[r].mag);
            check($sformatf("tbl%0d.phase", r), 64'(o_phase), 64'(tbl[r].exp_ph));
            check($sformatf("tbl%0d.iter", r), 64'(o_iter_count), 64'(tbl[r].exp_iter));
            check($sformatf("tbl%0d.timeout", r), 64'(o_timeout), 64'(tbl[r].exp_to));
            check($sformatf("tbl%0d.update", r), 64'(o_update_en), 64'(tbl[r].exp_upd));
        end

        // Timeout is sticky in LMS, restart clears everything
        run_samples(5, 2000);
        check("sticky.timeout", 64'(o_timeout), 64'(1));
        do_restart();
        check("restart.phase", 64'(o_phase), 64'(3'b000));
        check("restart.timeout", 64'(o_timeout), 64'(0));
        check("restart.iter", 64'(o_iter_count), 64'(0));
        check("restart.pow", 64'(o_err_pow), 64'(0));

        // Freeze in CMA: dwell and decimator pause, no strobes
        set_cfg(3, 14, 5000, 1000, 0);
        do_restart();
        run_samples(STARTUP_DELAY + 10, 4);
        check("frz.pre_phase", 64'(o_phase), 64'(3'b001));
        check("frz.pre_iter", 64'(o_iter_count), 64'(2));
        i_freeze = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_samples(1, 4);
            check("frz.hold_phase", 64'(o_phase), 64'(3'b011));
            check("frz.hold_update", 64'(o_update_en), 64'(0));
        end
        i_freeze = 1'b0;
        run_samples(1, 4);
        check("frz.release_phase", 64'(o_phase), 64'(3'b001));
        run_samples(2, 4);
        check("frz.resume_update", 64'(o_update_en), 64'(1));
        check("frz.resume_iter", 64'(o_iter_count), 64'(3));
        run_samples(1, 4);
        check("frz.sample13", 64'(o_phase), 64'(3'b001));
        run_samples(1, 4);
        check("frz.sample14", 64'(o_phase), 64'(3'b010));
        do_restart();
        check("frz.restart_phase", 64'(o_phase), 64'(3'b000));
        check("frz.restart_iter", 64'(o_iter_count), 64'(0));

        // Divergence in LMS (fallback only with the build option)
        set_cfg(0, 1, 5000, 1000, 500);
        do_restart();
        run_samples(STARTUP_DELAY + 1, 4);
        check("div.lms", 64'(o_phase), 64'(3'b010));
        for (int k = 0; k < 50 && o_phase != 3'b001; k++) begin
            run_samples(1, 100);
        end
        check("div.phase", 64'(o_phase), FALLBACK ? 64'(3'b001) : 64'(3'b010));
        check("div.flag", 64'(o_diverged), 64'(FALLBACK));

        // Disable: IDLE, counters cleared, power and flags kept
        pow_before = m_pow;
        enable = 1'b0;
        run_samples(3, 100);
        check("dis.phase", 64'(o_phase), 64'(3'b000));
        check("dis.iter", 64'(o_iter_count), 64'(0));
        check("dis.pow_kept", 64'(o_err_pow), 64'(pow_before));
        check("dis.flag_kept", 64'(o_diverged), 64'(FALLBACK));
        enable = 1'b1;
        run_samples(1, 100);

        // Reset in the middle of LMS
        set_cfg(0, 1, 5000, 1000, 100000);
        do_restart();
        run_samples(STARTUP_DELAY + 6, 20);
        check("rstlms.pre_phase", 64'(o_phase), 64'(3'b010));
        rst_n = 1'b0;
        run_samples(1, 20);
        rst_n = 1'b1;
        check("rstlms.phase", 64'(o_phase), 64'(3'b000));
        check("rstlms.update", 64'(o_update_en), 64'(0));
        check("rstlms.iter", 64'(o_iter_count), 64'(0));
        check("rstlms.pow", 64'(o_err_pow), 64'(0));

        // Randomized run against the model
        randomize_cfg();
        for (int c = 0; c < 3000; c++) begin
            int val;
            rst_n     = ($urandom_range(0, 499) != 0);
            enable    = ($urandom_range(0, 199) != 0);
            i_restart = ($urandom_range(0, 399) == 0);
            if (i_restart || !rst_n) randomize_cfg();
            if (frz_left > 0) begin
                i_freeze = 1'b1;
                frz_left--;
            end else begin
                i_freeze = 1'b0;
                if ($urandom_range(0, 59) == 0) frz_left = int'($urandom_range(1, 6));
            end
            i_err_valid = ($urandom_range(0, 3) != 0);
            val = int'($urandom_range(0, 2 * err_mag)) - err_mag;
            if (val > 131071) val = 131071;
            i_err = NB_ERR'(val);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
